// File: rtl/filter_select_ctrl_if.sv
// Filter-selection handshake bundle: raw buttons and menu enable in, select pulses and menu state out.
// The master side is the button/menu controller; the slave side is the filter block and overlay.
interface filter_select_ctrl_if;
    logic       menu_en;
    logic       btn_up;
    logic       btn_down;
    logic       btn_enter;
    logic       select0;
    logic       select1;
    logic       select2;
    logic       select3;
    logic       filters_en;
    logic       filters_user_in_en;
    logic [1:0] cursor;
    logic [1:0] committed;

    modport master (
        input  menu_en,
        input  btn_up,
        input  btn_down,
        input  btn_enter,
        output select0,
        output select1,
        output select2,
        output select3,
        output filters_en,
        output filters_user_in_en,
        output cursor,
        output committed
    );

    modport slave (
        output menu_en,
        output btn_up,
        output btn_down,
        output btn_enter,
        input  select0,
        input  select1,
        input  select2,
        input  select3,
        input  filters_en,
        input  filters_user_in_en,
        input  cursor,
        input  committed
    );
endinterface

// File: rtl/filter_select_ctrl.sv
// Button debouncer, 4-entry menu cursor and one-cycle filter select commit for the filter pipeline.
// Optional hold-to-repeat cursor stepping is enabled by defining FILTER_SEL_AUTO_REPEAT_EN.
module filter_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 16250000
) (
    input  logic                 clk,
    input  logic                 rst,
    filter_select_ctrl_if.master bus
);

    localparam int NB    = 3;
    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int ENTER = 2;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BROWSE,
        COMMIT,
        WAIT_RELEASE
    } state_t;

    logic [NB-1:0]    rawBtn;
    logic [NB-1:0]    meta_q;
    logic [NB-1:0]    sync_q;
    logic [NB-1:0]    deb_q;
    logic [NB-1:0]    deb_d;
    logic [NB-1:0]    debPrev_q;
    logic [NB-1:0]    pressEv;
    logic [CNT_W-1:0] bounceCnt_q [NB];
    logic [CNT_W-1:0] bounceCnt_d [NB];

    state_t     state_q;
    state_t     state_d;
    logic [1:0] cursor_q;
    logic [1:0] cursor_d;
    logic [1:0] committed_q;
    logic [1:0] committed_d;
    logic [3:0] select_q;
    logic [3:0] select_d;
    logic       filtersEn_q;
    logic       filtersEn_d;
    logic       userInEn_q;
    logic       userInEn_d;
    logic       upStep;
    logic       downStep;

    assign rawBtn  = {bus.btn_enter, bus.btn_down, bus.btn_up};
    assign pressEv = deb_q & ~debPrev_q;

    // A button's debounced level flips only after the synced input disagrees for a full run.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            bounceCnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (bounceCnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    bounceCnt_d[i] = bounceCnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q    <= '0;
            sync_q    <= '0;
            deb_q     <= '0;
            debPrev_q <= '0;
            for (int i = 0; i < NB; i++) begin
                bounceCnt_q[i] <= '0;
            end
        end else begin
            meta_q    <= rawBtn;
            sync_q    <= meta_q;
            deb_q     <= deb_d;
            debPrev_q <= deb_q;
            for (int i = 0; i < NB; i++) begin
                bounceCnt_q[i] <= bounceCnt_d[i];
            end
        end
    end

`ifdef FILTER_SEL_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES);

    logic [RPT_W-1:0] repeatCnt_q;
    logic [RPT_W-1:0] repeatCnt_d;
    logic             holdUp;
    logic             holdDown;
    logic             repeatFire;

    // Counter tracks cycles since the current single-direction hold began in BROWSE.
    always_comb begin
        holdUp      = deb_q[UP] & ~deb_q[DOWN];
        holdDown    = deb_q[DOWN] & ~deb_q[UP];
        repeatFire  = 1'b0;
        repeatCnt_d = '0;
        if (state_q == BROWSE && (holdUp || holdDown)) begin
            if (pressEv[UP] || pressEv[DOWN]) begin
                repeatCnt_d = RPT_W'(1);
            end else if (repeatCnt_q == RPT_LAST) begin
                repeatFire  = 1'b1;
                repeatCnt_d = RPT_W'(1);
            end else begin
                repeatCnt_d = repeatCnt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            repeatCnt_q <= '0;
        end else begin
            repeatCnt_q <= repeatCnt_d;
        end
    end

    assign upStep   = pressEv[UP] | (repeatFire & holdUp);
    assign downStep = pressEv[DOWN] | (repeatFire & holdDown);
`else
    logic unusedRepeatCfg;

    assign unusedRepeatCfg = (REPEAT_CYCLES > 0);
    assign upStep          = pressEv[UP];
    assign downStep        = pressEv[DOWN];
`endif

    // Select pulses and filters_en are registered on entry to COMMIT so they are glitch-free.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        committed_d = committed_q;
        filtersEn_d = filtersEn_q;
        select_d    = '0;
        userInEn_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.menu_en) begin
                    state_d = BROWSE;
                end
            end
            BROWSE: begin
                if (!bus.menu_en) begin
                    state_d = IDLE;
                end else if (pressEv[ENTER]) begin
                    state_d     = COMMIT;
                    select_d    = 4'b0001 << cursor_q;
                    userInEn_d  = 1'b1;
                    filtersEn_d = (cursor_q != 2'd3);
                end else if (upStep && !downStep) begin
                    cursor_d = cursor_q + 2'd1;
                end else if (downStep && !upStep) begin
                    cursor_d = cursor_q - 2'd1;
                end
            end
            COMMIT: begin
                committed_d = cursor_q;
                state_d     = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!bus.menu_en) begin
                    state_d = IDLE;
                end else if (!deb_q[ENTER]) begin
                    state_d = BROWSE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cursor_q    <= 2'd0;
            committed_q <= 2'd3;
            select_q    <= '0;
            filtersEn_q <= 1'b0;
            userInEn_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            committed_q <= committed_d;
            select_q    <= select_d;
            filtersEn_q <= filtersEn_d;
            userInEn_q  <= userInEn_d;
        end
    end

    assign bus.select0            = select_q[0];
    assign bus.select1            = select_q[1];
    assign bus.select2            = select_q[2];
    assign bus.select3            = select_q[3];
    assign bus.filters_en         = filtersEn_q;
    assign bus.filters_user_in_en = userInEn_q;
    assign bus.cursor             = cursor_q;
    assign bus.committed          = committed_q;

endmodule

// File: tb/tb_filter_select_ctrl.sv
// Self-checking bench for filter_select_ctrl: directed menu scenarios plus random button activity
// compared every cycle against a press-latency based behavioural model of the menu.
module tb_filter_select_ctrl;

    localparam int DEB = 4;
    localparam int RPT = 8;
    localparam int LAT = 2 + DEB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   pulseCount = 0;

    filter_select_ctrl_if bus();

    filter_select_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(3),
        .REPEAT_CYCLES(RPT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 browse, 2 commit, 3 wait-release; effHist[k] is the clean button state k cycles ago.
    int         mMode;
    int         mCursor;
    int         mCommitted;
    logic       mFen;
    int         mRun;
    logic [2:0] effHist [LAT + 2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [9:0] packOutputs();
        return {bus.select3, bus.select2, bus.select1, bus.select0, bus.filters_en,
                bus.filters_user_in_en, bus.cursor, bus.committed};
    endfunction

    function automatic logic [9:0] modelOutputs();
        logic [3:0] sel;
        sel = 4'b0;
        if (mMode == 2) sel[mCursor] = 1'b1;
        return {sel, mFen, logic'(mMode == 2), 2'(mCursor), 2'(mCommitted)};
    endfunction

    task automatic modelReset();
        mMode      = 0;
        mCursor    = 0;
        mCommitted = 3;
        mFen       = 1'b0;
        mRun       = 0;
        for (int k = 0; k < LAT + 2; k++) effHist[k] = 3'b000;
    endtask

    // A clean press becomes a debounced level LAT cycles later; its rising edge is the press event.
    task automatic modelClock(input logic [2:0] eff, input logic menu);
        logic [2:0] debNow;
        logic [2:0] ev;
        logic       upStep;
        logic       downStep;
        for (int k = LAT + 1; k > 0; k--) effHist[k] = effHist[k-1];
        effHist[0] = eff;
        debNow   = effHist[LAT];
        ev       = debNow & ~effHist[LAT + 1];
        upStep   = ev[0];
        downStep = ev[1];
`ifdef FILTER_SEL_AUTO_REPEAT_EN
        if (mMode == 1 && debNow[0] != debNow[1]) mRun++;
        else mRun = 0;
        if (mRun > 1 && (mRun - 1) % RPT == 0) begin
            if (debNow[0]) upStep = 1'b1;
            else downStep = 1'b1;
        end
`endif
        case (mMode)
            0: if (menu) mMode = 1;
            1: begin
                if (!menu) mMode = 0;
                else if (ev[2]) begin
                    mMode = 2;
                    mFen  = (mCursor != 3);
                end else if (upStep && !downStep) mCursor = (mCursor + 1) % 4;
                else if (downStep && !upStep) mCursor = (mCursor + 3) % 4;
            end
            2: begin
                mCommitted = mCursor;
                mMode      = 3;
            end
            default: begin
                if (!menu) mMode = 0;
                else if (!debNow[2]) mMode = 1;
            end
        endcase
    endtask

    // One clock: drive raw buttons, advance the model with the clean view, compare all outputs.
    task automatic applyStimulus(input logic [2:0] raw, input logic [2:0] eff, input logic menu);
        @(negedge clk);
        bus.btn_up    = raw[0];
        bus.btn_down  = raw[1];
        bus.btn_enter = raw[2];
        bus.menu_en   = menu;
        @(posedge clk);
        modelClock(eff, menu);
        #1;
        checkOutput("outputs", 32'(packOutputs()), 32'(modelOutputs()));
        if ({bus.select3, bus.select2, bus.select1, bus.select0} != 4'b0) pulseCount++;
    endtask

    task automatic pressButtons(input logic [2:0] mask, input bit glitch, input int hold, input int gap,
                                input logic menu);
        for (int i = 0; i < hold; i++) applyStimulus(mask, glitch ? 3'b000 : mask, menu);
        for (int i = 0; i < gap; i++) applyStimulus(3'b000, 3'b000, menu);
    endtask

    initial begin
        int   hit;
        int   pulsesBefore;
        bit   reached;
        logic [2:0] mask;
        int   r;

        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_enter = 1'b0;
        bus.menu_en   = 1'b0;
        modelReset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("resetState", 32'(packOutputs()), 32'h003);
        @(negedge clk) rst = 1'b1;

        pressButtons(3'b000, 1'b0, 0, 3, 1'b1);
        pressButtons(3'b001, 1'b1, 3, 8, 1'b1);
        checkOutput("glitchCursor", 32'(bus.cursor), 32'd0);

        hit = 0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(3'b001, 3'b001, 1'b1);
            if (bus.cursor == 2'd1 && hit == 0) hit = i;
        end
        pressButtons(3'b000, 1'b0, 0, 8, 1'b1);
        checkOutput("upLatency", 32'(hit), 32'd7);

        for (int i = 0; i < 3; i++) pressButtons(3'b001, 1'b0, 6, 8, 1'b1);
        checkOutput("wrapUp", 32'(bus.cursor), 32'd0);
        pressButtons(3'b010, 1'b0, 6, 8, 1'b1);
        checkOutput("wrapDown", 32'(bus.cursor), 32'd3);
        pressButtons(3'b010, 1'b0, 6, 8, 1'b1);

        pulsesBefore = pulseCount;
        pressButtons(3'b100, 1'b0, 50, 8, 1'b1);
        checkOutput("enterHeldPulses", 32'(pulseCount - pulsesBefore), 32'd1);
        checkOutput("commit2", 32'(bus.committed), 32'd2);
        checkOutput("commit2Fen", 32'(bus.filters_en), 32'd1);

        pressButtons(3'b010, 1'b0, 6, 8, 1'b1);
        pressButtons(3'b101, 1'b0, 6, 8, 1'b1);
        checkOutput("upEnterCursor", 32'(bus.cursor), 32'd1);
        checkOutput("upEnterCommit", 32'(bus.committed), 32'd1);
        pressButtons(3'b011, 1'b0, 6, 8, 1'b1);
        checkOutput("upDownCancel", 32'(bus.cursor), 32'd1);

        pressButtons(3'b010, 1'b0, 6, 8, 1'b1);
        pressButtons(3'b010, 1'b0, 6, 8, 1'b1);
        pressButtons(3'b100, 1'b0, 6, 8, 1'b1);
        checkOutput("commitNone", 32'(bus.committed), 32'd3);
        checkOutput("commitNoneFen", 32'(bus.filters_en), 32'd0);
        pressButtons(3'b001, 1'b0, 6, 8, 1'b1);
        pressButtons(3'b100, 1'b0, 6, 8, 1'b1);
        pressButtons(3'b001, 1'b0, 6, 8, 1'b0);
        checkOutput("menuOffCursor", 32'(bus.cursor), 32'd0);
        checkOutput("menuOffFen", 32'(bus.filters_en), 32'd1);

        for (int a = 0; a < 250; a++) begin
            r = $urandom_range(0, 9);
            if (r < 4) mask = 3'b001;
            else if (r < 7) mask = 3'b010;
            else if (r == 7) mask = 3'b100;
            else if (r == 8) mask = 3'b011;
            else mask = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 4) == 0)
                pressButtons(mask, 1'b1, $urandom_range(1, DEB - 1), $urandom_range(DEB, 10),
                             $urandom_range(0, 9) != 0);
            else
                pressButtons(mask, 1'b0, $urandom_range(DEB, 12), $urandom_range(DEB, 10),
                             $urandom_range(0, 9) != 0);
        end

        pressButtons(3'b000, 1'b0, 0, 8, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            applyStimulus(3'b100, 3'b100, 1'b1);
            if (mMode == 2) reached = 1'b1;
        end
        checkOutput("commitReached", 32'(reached), 32'd1);
        @(negedge clk);
        rst           = 1'b0;
        bus.btn_enter = 1'b0;
        #1 checkOutput("resetInCommit", 32'(packOutputs()), 32'h003);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        pressButtons(3'b000, 1'b0, 0, 10, 1'b1);
        pressButtons(3'b001, 1'b0, 6, 8, 1'b1);
        checkOutput("afterResetUp", 32'(bus.cursor), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/filter_select_ctrl.md
Name: filter_select_ctrl

Overview:
- User-side initiator for the filter-selection interface of the filter pipeline; drives the select0..select3 / filters_en / filters_user_in_en handshake that the filter block samples.
- Debounces raw up/down/enter buttons, maintains a 4-entry menu cursor (SEPIA, INVERT, GRAYSCALE, NONE), and commits the highlighted entry as a one-cycle select pulse.
- Sits between the board button inputs and the filter block; cursor and committed index also feed the on-screen menu overlay.

Parameters:
- DEBOUNCE_CYCLES, 650000, consecutive stable cycles required before a debounced button changes (10 ms at 65 MHz)
- CNT_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES
- REPEAT_CYCLES, 16250000, hold time per auto-repeat step (used only with the optional feature)

Ports:
- clk  input  1  system pixel clock
- rst  input  1  asynchronous, active-low reset
- menu_en  input  1  filter menu active; cursor moves and commits only while high
- btn_up  input  1  raw, asynchronous, bouncy up button, active-high
- btn_down  input  1  raw down button, active-high
- btn_enter  input  1  raw enter button, active-high
- select0  output  1  one-cycle commit pulse for SEPIA
- select1  output  1  one-cycle commit pulse for INVERT
- select2  output  1  one-cycle commit pulse for GRAYSCALE
- select3  output  1  one-cycle commit pulse for NONE (filter bypass)
- filters_en  output  1  level; high while a non-NONE filter is committed
- filters_user_in_en  output  1  high only in the COMMIT cycle
- cursor  output  2  highlighted entry: 0=SEPIA, 1=INVERT, 2=GRAYSCALE, 3=NONE
- committed  output  2  last committed entry

Behaviour:
- Reset, asynchronous with rst low: all selects 0, filters_en 0, filters_user_in_en 0, cursor 0, committed 3, state IDLE, synchronizers and counters cleared. Reset may occur in any state, including mid-COMMIT; the pulse is dropped and no partial commit remains.
- Input conditioning, per button:
  - 2-FF synchronizer.
  - Debounced level toggles after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing cycle clears the counter.
  - A rising edge of the debounced level gives a one-cycle press event.
- Press-to-effect latency: 2 + DEBOUNCE_CYCLES cycles to the press event, plus 1 cycle to the cursor change or COMMIT.
- States:
  - IDLE: menu_en high moves to BROWSE. Outputs hold, user_in_en 0.
  - BROWSE:
    - up event: cursor+1, wraps 3 to 0.
    - down event: cursor-1, wraps 0 to 3.
    - up and down in the same cycle: no move.
    - enter event moves to COMMIT and wins over a same-cycle up/down, which is discarded.
    - menu_en low moves to IDLE.
  - COMMIT, exactly one cycle:
    - select[cursor] = 1, all other selects 0, filters_user_in_en = 1, committed <= cursor.
    - filters_en = 1 in this same cycle if cursor != 3, so the filter block samples the select.
    - cursor == 3: filters_en = 0 from this cycle on.
    - Then WAIT_RELEASE.
  - WAIT_RELEASE: up/down ignored. Moves to BROWSE once debounced enter is low, or to IDLE if menu_en is low.
- filters_en changes only in COMMIT or reset. menu_en low never clears it.
- At most one select is high in any cycle. Selects are 0 outside COMMIT.
- Re-committing the same entry still produces a pulse.

Optional Feature:
- Macro: FILTER_SEL_AUTO_REPEAT_EN.
- Defined: in BROWSE, holding debounced up (or down) alone produces an extra step every REPEAT_CYCLES after the initial press event. The repeat counter clears on release, on state exit, or when both buttons are held.
- Undefined: one step per press; no repeat counter is synthesized.

Test Plan:
- Use DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8 for all scenarios.
- Reset release: all outputs at reset values (committed=3, filters_en=0); raw up pulsed high for 3 cycles with menu_en=1 -> cursor stays 0 (bounce rejected).
- menu_en=1, clean up press held 10 cycles -> cursor changes 0 to 1 exactly 7 cycles after the raw rise; four up presses from 0 -> 1,2,3,0 (wrap); one down from 0 -> 3.
- cursor=2, enter press -> single cycle with select2=1, filters_user_in_en=1, filters_en=1; next cycle select2=0, committed=2; enter held 50 cycles -> no second pulse.
- Up and enter events in the same cycle at cursor=1 -> select1 pulse, cursor stays 1; up and down events together -> cursor unchanged.
- Commit at cursor=3 -> select3 pulse, filters_en=0; menu_en low then up press -> cursor unchanged, filters_en unchanged.
- rst asserted in the COMMIT cycle -> select/user_in_en drop immediately, committed=3; with the macro defined, up held 30 cycles past debounce -> steps at 0, 8, 16, 24 cycles after the press event.
